// File: rtl/mem_access_seq.sv
// Sequencer for the shared instruction/data memory port: hides the one-cycle read
// latency, performs read-modify-write for sub-word stores and flags illegal accesses.
module mem_access_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_WAIT,
        WRITE,
        RESP
    } state_t;

    typedef enum logic [2:0] {
        OP_LW = 3'b000,
        OP_LH = 3'b001,
        OP_LB = 3'b010,
        OP_SW = 3'b100,
        OP_SH = 3'b101,
        OP_SB = 3'b110
    } op_t;

    state_t      state;
    state_t      state_nx;
    logic        req_err;
    logic [2:0]  op_q;
    logic [1:0]  addr_lo_q;
    logic [15:0] wdata_lo_q;

    function automatic logic [7:0] byte_sel(input logic [1:0] k, input logic [31:0] word);
        logic [7:0] b;
        case (k)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0]  op,
                                                 input logic [1:0]  lo,
                                                 input logic [31:0] word);
        logic [31:0] r;
        r = '0;
        case (op)
            OP_LW:   r = word;
            OP_LH:   r = {16'h0000, (lo[1] ? word[31:16] : word[15:0])};
            OP_LB:   r = {24'h000000, byte_sel(lo, word)};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Only the addressed half/byte of the freshly read word is replaced.
    function automatic logic [31:0] store_merge(input logic [2:0]  op,
                                                input logic [1:0]  lo,
                                                input logic [15:0] wd,
                                                input logic [31:0] word);
        logic [31:0] r;
        r = word;
        if (op == OP_SH) begin
            if (lo[1]) r[31:16] = wd;
            else       r[15:0]  = wd;
        end else begin
            case (lo)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end
        return r;
    endfunction

    always_comb begin
        req_err = 1'b0;
        case (req_op)
            OP_LW:                      req_err = (req_addr[1:0] != 2'b00);
            OP_LH:                      req_err = req_addr[0];
            OP_LB, OP_SW, OP_SH, OP_SB: req_err = 1'b0;
            default:                    req_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)             state_nx = RESP;
                    else if (req_op == OP_SW) state_nx = WRITE;
                    else                     state_nx = RD_ADDR;
                end
            end
            RD_ADDR: state_nx = RD_WAIT;
            RD_WAIT: state_nx = op_q[2] ? WRITE : RESP;
            WRITE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && !reset;
        rsp_valid = (state == RESP);
        mem_wr    = (state == WRITE);
    end

    // Response registers change only on the edge entering RESP, so they hold between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            op_q       <= '0;
            addr_lo_q  <= '0;
            wdata_lo_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q       <= req_op;
                        addr_lo_q  <= req_addr[1:0];
                        wdata_lo_q <= req_wdata[15:0];
                        if (req_err) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            mem_addr <= {req_addr[31:2], 2'b00};
                            if (req_op == OP_SW) mem_wdata <= req_wdata;
                        end
                    end
                end
                RD_WAIT: begin
                    if (op_q[2]) begin
                        mem_wdata <= store_merge(op_q, addr_lo_q, wdata_lo_q, mem_rdata);
                    end else begin
                        rsp_rdata <= load_extract(op_q, addr_lo_q, mem_rdata);
                        rsp_err   <= 1'b0;
                    end
                end
                WRITE: begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Randomized self-checking bench for mem_access_seq against a byte-addressed
// reference memory and a per-opcode timing table.
module tb_mem_access_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_words [0:255];
    logic [7:0]  ref_bytes [0:1023];
    logic        load_en = 1'b0;
    logic [7:0]  load_idx = '0;
    logic [31:0] load_val = '0;

    mem_access_seq dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory with one-cycle registered read; preloaded through load_en during reset.
    always @(posedge clk) begin
        if (load_en) mem_words[load_idx] <= load_val;
        else if (mem_wr === 1'b1) mem_words[mem_addr[9:2]] <= mem_wdata;
        mem_rdata <= mem_words[mem_addr[9:2]];
    end

    function automatic logic [31:0] ref_word(input int unsigned byte_addr);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w = w | (32'(ref_bytes[(byte_addr & ~32'd3) + i]) << (8 * i));
        return w;
    endfunction

    // Reference: byte-granular memory, size-aligned accesses, fixed per-class latencies.
    task automatic model_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                             output logic e_err, output logic [31:0] e_rdata,
                             output int e_rsp, output int e_wr, output logic [31:0] e_word);
        int unsigned size, start, a;
        bit is_store, legal;
        a = int'(addr & 32'h3FF);
        legal = 1; is_store = 0; size = 4;
        case (op)
            3'b000: size = 4;
            3'b001: size = 2;
            3'b010: size = 1;
            3'b100: begin size = 4; is_store = 1; end
            3'b101: begin size = 2; is_store = 1; end
            3'b110: begin size = 1; is_store = 1; end
            default: legal = 0;
        endcase
        e_rdata = '0; e_wr = -1; e_word = '0; e_rsp = 1;
        e_err = !legal || (!is_store && (a % size) != 0);
        if (e_err) return;
        start = a & ~(size - 1);
        if (!is_store) begin
            for (int i = 0; i < int'(size); i++) e_rdata = e_rdata | (32'(ref_bytes[start + i]) << (8 * i));
            e_rsp = 3;
        end else begin
            for (int i = 0; i < int'(size); i++) ref_bytes[start + i] = wd[8*i +: 8];
            e_wr   = (size == 4) ? 1 : 3;
            e_rsp  = e_wr + 1;
            e_word = ref_word(a);
        end
    endtask

    task automatic do_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          output logic rdy, output int rsp_cyc, output logic [31:0] rdata,
                          output logic err, output int wr_cnt, output int wr_cyc,
                          output logic [31:0] wr_addr, output logic [31:0] wr_data);
        @(negedge clk);
        rdy = req_ready;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        rsp_cyc = -1; wr_cnt = 0; wr_cyc = -1;
        rdata = 'x; err = 1'bx; wr_addr = 'x; wr_data = 'x;
        for (int k = 1; k <= 8 && rsp_cyc < 0; k++) begin
            @(negedge clk);
            req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
            if (mem_wr === 1'b1) begin wr_cnt++; wr_cyc = k; wr_addr = mem_addr; wr_data = mem_wdata; end
            if (rsp_valid === 1'b1) begin rsp_cyc = k; rdata = rsp_rdata; err = rsp_err; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            v = (i == 32'h40) ? 32'hAABBCCDD : $urandom;
            load_en = 1'b1; load_idx = 8'(i); load_val = v;
            for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = v[8*b +: 8];
        end
        @(negedge clk);
        load_en = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin $display("FAIL reset_ready_low: got %b expected 0", req_ready); errors++; end
        checks++;
        if ({mem_addr, mem_wdata, rsp_rdata, rsp_err, rsp_valid, mem_wr} !== '0) begin
            $display("FAIL reset_values: addr %h wdata %h rdata %h err %b valid %b wr %b expected all 0",
                     mem_addr, mem_wdata, rsp_rdata, rsp_err, rsp_valid, mem_wr);
            errors++;
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin $display("FAIL reset_release_ready: got %b expected 1", req_ready); errors++; end
    endtask

    task automatic test_load();
        logic rdy, err, e_err; logic [31:0] rdata, wa, wdd, e_rd, e_wd; int rc, wn, wc, e_rc, e_wc;
        model_txn(3'b010, 32'h102, 32'h0, e_err, e_rd, e_rc, e_wc, e_wd);
        do_txn(3'b010, 32'h102, $urandom, rdy, rc, rdata, err, wn, wc, wa, wdd);
        checks++;
        if (rdy !== 1'b1 || rc != 3) begin $display("FAIL lb_timing: ready %b rsp cycle %0d expected 1 / 3", rdy, rc); errors++; end
        checks++;
        if (rdata !== 32'h000000BB || err !== 1'b0 || wn != 0) begin
            $display("FAIL lb_data: rdata %h err %b writes %0d expected 000000bb 0 0", rdata, err, wn); errors++;
        end
        @(negedge clk);
        checks++;
        if (rsp_rdata !== 32'h000000BB || rsp_valid !== 1'b0) begin
            $display("FAIL rsp_hold: rdata %h valid %b expected 000000bb 0", rsp_rdata, rsp_valid); errors++;
        end
        model_txn(3'b001, 32'h102, 32'h0, e_err, e_rd, e_rc, e_wc, e_wd);
        do_txn(3'b001, 32'h102, $urandom, rdy, rc, rdata, err, wn, wc, wa, wdd);
        checks++;
        if (rc != 3 || rdata !== 32'h0000AABB || err !== 1'b0 || wn != 0) begin
            $display("FAIL lh: cycle %0d rdata %h err %b writes %0d expected 3 0000aabb 0 0", rc, rdata, err, wn); errors++;
        end
        model_txn(3'b000, 32'h100, 32'h0, e_err, e_rd, e_rc, e_wc, e_wd);
        do_txn(3'b000, 32'h100, $urandom, rdy, rc, rdata, err, wn, wc, wa, wdd);
        checks++;
        if (rc != 3 || rdata !== 32'hAABBCCDD || err !== 1'b0 || wn != 0) begin
            $display("FAIL lw: cycle %0d rdata %h err %b writes %0d expected 3 aabbccdd 0 0", rc, rdata, err, wn); errors++;
        end
    endtask

    task automatic test_rmw();
        logic rdy, err, e_err; logic [31:0] rdata, wa, wdd, e_rd, e_wd; int rc, wn, wc, e_rc, e_wc;
        model_txn(3'b101, 32'h102, 32'h12345678, e_err, e_rd, e_rc, e_wc, e_wd);
        do_txn(3'b101, 32'h102, 32'h12345678, rdy, rc, rdata, err, wn, wc, wa, wdd);
        checks++;
        if (wn != 1 || wc != 3 || wa !== 32'h100 || wdd !== 32'h5678CCDD) begin
            $display("FAIL sh_write: count %0d cycle %0d addr %h data %h expected 1 3 00000100 5678ccdd", wn, wc, wa, wdd); errors++;
        end
        checks++;
        if (rc != 4 || rdata !== 32'h0 || err !== 1'b0) begin
            $display("FAIL sh_rsp: cycle %0d rdata %h err %b expected 4 00000000 0", rc, rdata, err); errors++;
        end
        model_txn(3'b000, 32'h100, 32'h0, e_err, e_rd, e_rc, e_wc, e_wd);
        do_txn(3'b000, 32'h100, $urandom, rdy, rc, rdata, err, wn, wc, wa, wdd);
        checks++;
        if (rc != 3 || rdata !== 32'h5678CCDD) begin
            $display("FAIL sh_readback: cycle %0d rdata %h expected 3 5678ccdd", rc, rdata); errors++;
        end
    endtask

    task automatic test_error();
        logic rdy, err, e_err; logic [31:0] rdata, wa, wdd, e_rd, e_wd; int rc, wn, wc, e_rc, e_wc;
        model_txn(3'b000, 32'h101, 32'h0, e_err, e_rd, e_rc, e_wc, e_wd);
        do_txn(3'b000, 32'h101, $urandom, rdy, rc, rdata, err, wn, wc, wa, wdd);
        checks++;
        if (rc != 1 || err !== 1'b1 || rdata !== 32'h0 || wn != 0) begin
            $display("FAIL lw_misaligned: cycle %0d err %b rdata %h writes %0d expected 1 1 0 0", rc, err, rdata, wn); errors++;
        end
        model_txn(3'b011, 32'h100, 32'h0, e_err, e_rd, e_rc, e_wc, e_wd);
        do_txn(3'b011, 32'h100, $urandom, rdy, rc, rdata, err, wn, wc, wa, wdd);
        checks++;
        if (rc != 1 || err !== 1'b1 || rdata !== 32'h0 || wn != 0) begin
            $display("FAIL illegal_op: cycle %0d err %b rdata %h writes %0d expected 1 1 0 0", rc, err, rdata, wn); errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic e_err; logic [31:0] e_rd, e_wd, w2; int e_rc, e_wc;
        logic [5:0] wr_v, rsp_v, rdy_v;
        logic [31:0] a1, d1, a4, d4;
        w2 = $urandom;
        model_txn(3'b100, 32'h200, 32'hDEADBEEF, e_err, e_rd, e_rc, e_wc, e_wd);
        model_txn(3'b100, 32'h204, w2, e_err, e_rd, e_rc, e_wc, e_wd);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b100; req_addr = 32'h200; req_wdata = 32'hDEADBEEF;
        a1 = 'x; d1 = 'x; a4 = 'x; d4 = 'x;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            wr_v[k-1] = mem_wr; rsp_v[k-1] = rsp_valid; rdy_v[k-1] = req_ready;
            if (k == 1) begin a1 = mem_addr; d1 = mem_wdata; req_addr = 32'h204; req_wdata = w2; end
            if (k == 4) begin a4 = mem_addr; d4 = mem_wdata; req_valid = 1'b0; end
        end
        checks++;
        if (wr_v !== 6'b001001 || rsp_v !== 6'b010010 || rdy_v !== 6'b100100) begin
            $display("FAIL b2b_timing: wr %b rsp %b ready %b expected 001001 010010 100100", wr_v, rsp_v, rdy_v); errors++;
        end
        checks++;
        if (a1 !== 32'h200 || d1 !== 32'hDEADBEEF || a4 !== 32'h204 || d4 !== w2) begin
            $display("FAIL b2b_data: %h/%h %h/%h expected 00000200/deadbeef 00000204/%h", a1, d1, a4, d4, w2); errors++;
        end
    endtask

    task automatic test_abort();
        int wr_seen, rsp_seen;
        logic rdy0, rdy3, rdy4;
        logic [31:0] word;
        wr_seen = 0; rsp_seen = 0;
        @(negedge clk);
        rdy0 = req_ready;
        req_valid = 1'b1; req_op = 3'b110; req_addr = 32'h103; req_wdata = $urandom;
        rdy3 = 1'bx; rdy4 = 1'bx;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (mem_wr !== 1'b0) wr_seen++;
            if (rsp_valid !== 1'b0) rsp_seen++;
            if (k == 1) req_valid = 1'b0;
            if (k == 2) reset = 1'b1;
            if (k == 3) begin
                rdy3 = req_ready;
                checks++;
                if ({mem_addr, mem_wdata, rsp_rdata, rsp_err} !== '0) begin
                    $display("FAIL abort_reset_values: addr %h wdata %h rdata %h err %b expected all 0",
                             mem_addr, mem_wdata, rsp_rdata, rsp_err);
                    errors++;
                end
                reset = 1'b0;
            end
            if (k == 4) rdy4 = req_ready;
        end
        checks++;
        if (wr_seen != 0 || rsp_seen != 0) begin
            $display("FAIL abort_quiet: writes %0d responses %0d expected 0 0", wr_seen, rsp_seen); errors++;
        end
        checks++;
        if (rdy0 !== 1'b1 || rdy3 !== 1'b0 || rdy4 !== 1'b1) begin
            $display("FAIL abort_ready: %b %b %b expected 1 0 1", rdy0, rdy3, rdy4); errors++;
        end
        word = ref_word(32'h100);
        checks++;
        if (mem_words[8'h40] !== word) begin
            $display("FAIL abort_mem: got %h expected %h", mem_words[8'h40], word); errors++;
        end
    endtask

    task automatic test_random();
        logic rdy, err, e_err; logic [31:0] rdata, wa, wdd, e_rd, e_wd, addr, wd; int rc, wn, wc, e_rc, e_wc;
        logic [2:0] op;
        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            addr = 32'h300 + $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            wd = $urandom;
            model_txn(op, addr, wd, e_err, e_rd, e_rc, e_wc, e_wd);
            do_txn(op, addr, wd, rdy, rc, rdata, err, wn, wc, wa, wdd);
            checks++;
            if (rdy !== 1'b1 || rc != e_rc || err !== e_err || rdata !== e_rd) begin
                $display("FAIL rand_rsp[%0d] op %b addr %h: ready %b cycle %0d err %b rdata %h expected 1 %0d %b %h",
                         n, op, addr, rdy, rc, err, rdata, e_rc, e_err, e_rd);
                errors++;
            end
            checks++;
            if (wn != (e_wc < 0 ? 0 : 1) ||
                (e_wc > 0 && (wc != e_wc || wa !== {addr[31:2], 2'b00} || wdd !== e_wd))) begin
                $display("FAIL rand_wr[%0d] op %b addr %h: count %0d cycle %0d addr %h data %h expected cycle %0d data %h",
                         n, op, addr, wn, wc, wa, wdd, e_wc, e_wd);
                errors++;
            end
        end
    endtask

    task automatic test_mem_final();
        int bad;
        bad = 0;
        @(negedge clk);
        for (int w = 0; w < 256; w++) if (mem_words[w] !== ref_word(32'(4 * w))) bad++;
        checks++;
        if (bad != 0) begin $display("FAIL mem_final: %0d words differ expected 0", bad); errors++; end
    endtask

    initial begin
        test_reset();
        test_load();
        test_rmw();
        test_error();
        test_back_to_back();
        test_abort();
        test_random();
        test_mem_final();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
